// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encodings and counter sizing for the serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter width: max(1, clog2(width)).
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_x,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_x;
    assign o_c = (i_a & i_b) | (i_x & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first through one full adder cell
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic [WIDTH-1:0]  sum_next;
    logic              carry;
    logic [CW-1:0]     count;
    logic              s;
    logic              c;
    logic              unused_lsb;

    full_adder u_fa (
        .i_a (a_sr[0]),
        .i_b (b_sr[0]),
        .i_x (carry),
        .o_s (s),
        .o_c (c)
    );

    // The bit shifted out of sum_sr on the final edge is already captured in o_sum.
    generate
        if (WIDTH == 1) begin : g_one
            assign sum_next = s;
        end else begin : g_many
            assign sum_next = {s, sum_sr[WIDTH-1:1]};
        end
    endgenerate
    assign unused_lsb = sum_sr[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (i_valid) next_state = ST_SHIFT;
            ST_SHIFT: if (count == LAST) next_state = ST_DONE;
            ST_DONE:  if (i_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            o_sum  <= '0;
            o_cout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_sr  <= i_a;
                        b_sr  <= i_b;
                        carry <= i_cin;
                        count <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= c;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        o_sum  <= sum_next;
                        o_cout <= c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       valid8 = 1'b0, ready_in8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, ovalid8, cout8;
    logic [7:0] sum8;

    logic       valid1 = 1'b0, ready_in1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ready1, ovalid1, cout1;
    logic [0:0] sum1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(ready8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .o_valid(ovalid8),
        .i_ready(ready_in8), .o_sum(sum8), .o_cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(ready1),
        .i_a(a1), .i_b(b1), .i_cin(cin1), .o_valid(ovalid1),
        .i_ready(ready_in1), .o_sum(sum1), .o_cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction: idle gap, accept, wait for result, hold in DONE, release.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] exp_sum, input logic exp_cout,
                       input int pre, input int hold, input bit chk_lat);
        int n;
        repeat (pre) tick();
        valid8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        n = 0;
        while (!ready8 && n < 50) begin tick(); n++; end
        if (n >= 50) check("ready_timeout", 32'(ready8), 32'd1);
        tick();
        valid8 = 1'b0;
        n = 0;
        while (!ovalid8 && n < 40) begin
            if (chk_lat) check("ready_low_busy", 32'(ready8), 32'd0);
            tick();
            n++;
        end
        if (chk_lat) check("latency", n, 32'd8);
        else if (n >= 40) check("valid_timeout", 32'(ovalid8), 32'd1);
        check("sum8", 32'(sum8), 32'(exp_sum));
        check("cout8", 32'(cout8), 32'(exp_cout));
        repeat (hold) begin
            valid8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
            check("hold_valid", 32'(ovalid8), 32'd1);
            check("hold_sum", {23'd0, cout8, sum8}, {23'd0, exp_cout, exp_sum});
        end
        valid8 = 1'b0;
        ready_in8 = 1'b1;
        tick();
        ready_in8 = 1'b0;
        check("release_valid", 32'(ovalid8), 32'd0);
        check("release_ready", 32'(ready8), 32'd1);
        check("release_sum", 32'(sum8), 32'(exp_sum));
    endtask

    task automatic op1(input int pre, input int hold);
        logic       a, b, c;
        logic [1:0] exp;
        int         n;
        a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
        exp = 2'(a) + 2'(b) + 2'(c);
        repeat (pre) tick();
        valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        tick();
        valid1 = 1'b0;
        n = 0;
        while (!ovalid1 && n < 10) begin tick(); n++; end
        check("latency1", n, 32'd1);
        check("result1", {30'd0, cout1, sum1}, {30'd0, exp});
        repeat (hold) begin
            valid1 = 1'($urandom); a1 = 1'($urandom);
            tick();
            check("hold1", {30'd0, ovalid1, sum1}, {30'd0, 1'b1, exp[0]});
        end
        valid1 = 1'b0;
        ready_in1 = 1'b1;
        tick();
        ready_in1 = 1'b0;
        check("release1", {30'd0, ovalid1, ready1}, 32'd1);
    endtask

    initial begin
        bit         saw_valid;
        logic [8:0] model;

        // Reset asserted mid-cycle takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_valid", 32'(ovalid8), 32'd0);
        check("rst_sum", 32'(sum8), 32'h00);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ready", 32'(ready8), 32'd1);
        tick(); tick();
        rst = 1'b0;

        op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1, 0, 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 2, 0, 1'b1);
        op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 0, 1'b1);
        op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, 5, 1'b1);
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 0, 1'b1);

        // Reset during the 4th SHIFT cycle aborts with no result.
        valid8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        tick();
        valid8 = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(ovalid8), 32'd0);
        check("abort_ready", 32'(ready8), 32'd1);
        saw_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (12) begin
            tick();
            if (ovalid8) saw_valid = 1'b1;
        end
        check("abort_no_pulse", 32'(saw_valid), 32'd0);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, model[7:0], model[8], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        for (int i = 0; i < 1000; i++) begin
            op1($urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
